// File: rtl/flash_pkg.sv
// flash_pkg: shared types and constants for the flash read responder.
package flash_pkg;
  localparam int FLASH_DATA_W = 32;
  localparam logic [15:0] FLASH_LFSR_SEED = 16'hACE1;
  typedef logic [FLASH_DATA_W-1:0] flash_word_t;
  typedef struct packed {
    logic        valid;
    flash_word_t data;
  } resp_stage_t;
  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
endpackage

// File: rtl/flash_read_responder_resp_pipe.sv
// resp_pipe: LATENCY-stage response shift register; the last stage drives readdata/readdatavalid.
module resp_pipe
  import flash_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  resp_stage_t issue,
  output flash_word_t readdata,
  output logic        readdatavalid,
  output logic        retire
);
  resp_stage_t pipe [LATENCY];
  resp_stage_t nxt [LATENCY];
  always_comb begin
    nxt[0] = issue;
    for (int i = 1; i < LATENCY; i++) nxt[i] = pipe[i-1];
  end
  // Stage data only moves with a valid word, so the output holds the last response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i].valid <= nxt[i].valid;
        pipe[i].data  <= nxt[i].valid ? nxt[i].data : pipe[i].data;
      end
    end
  end
  assign retire        = nxt[LATENCY-1].valid;
  assign readdata      = pipe[LATENCY-1].data;
  assign readdatavalid = pipe[LATENCY-1].valid;
endmodule

// File: rtl/flash_read_responder.sv
// flash_read_responder: Avalon-MM pipelined read responder over a loadable word array.
// Define FLASH_RESP_STALL_EN for LFSR-driven pseudo-random waitrequest.
module flash_read_responder
  import flash_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int LATENCY  = 3,
  parameter int MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flash_mem_read,
  input  logic [ADDR_W-1:0] flash_mem_address,
  output logic              flash_mem_waitrequest,
  output flash_word_t       flash_mem_readdata,
  output logic              flash_mem_readdatavalid,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  flash_word_t       load_data,
  output logic [31:0]       read_count
);
  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(MAX_PEND);
  flash_word_t mem [2**ADDR_W];
  logic [PEND_W-1:0] pending;
  logic accept, retire, full;
  assign full   = pending == PEND_FULL;
  assign accept = flash_mem_read && !flash_mem_waitrequest;
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
  end
  resp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue         ('{valid: accept, data: mem[flash_mem_address]}),
    .readdata      (flash_mem_readdata),
    .readdatavalid (flash_mem_readdatavalid),
    .retire        (retire)
  );
  // A slot frees as its response moves into the output stage, so MAX_PEND==LATENCY streams.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      read_count <= '0;
    end else begin
      pending    <= pending + PEND_W'(accept) - PEND_W'(retire);
      read_count <= read_count + 32'(accept);
    end
  end
`ifdef FLASH_RESP_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= FLASH_LFSR_SEED;
    else lfsr <= lfsr_next(lfsr);
  end
  assign flash_mem_waitrequest = full || (lfsr[1:0] == 2'b00);
`else
  assign flash_mem_waitrequest = full;
`endif
endmodule
